regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised successor to the single-write, dual-read CPU register file. Provides NUM_REGS x DATA_W storage with NUM_READ combinational read ports and NUM_WRITE synchronous write ports. Each write port has per-byte write strobes, for partial-word loads such as LWL/LWR. Also provides a dedicated debug read of a fixed register (v0) for the CPU top-level output, and sits between decode (reads) and writeback (writes) in the pipelined CPU.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
NUM_REGS, 32, number of architectural registers; power of two, >= 2
ADDR_W, $clog2(NUM_REGS), register address width
NUM_READ, 2, number of read ports, 1..4
NUM_WRITE, 2, number of write ports, 1..2
DEBUG_REG, 2, index of register driven on debug_data_o (MIPS v0)

Ports:
clk  input  1  rising-edge clock
reset_i  input  1  asynchronous, active-high reset
read_addr_i  input  NUM_READ*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
read_data_o  output  NUM_READ*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W]
write_enable_i  input  NUM_WRITE  per-port write enable
write_addr_i  input  NUM_WRITE*ADDR_W  packed write addresses
write_strobe_i  input  NUM_WRITE*(DATA_W/8)  per-port byte strobes; bit b covers bits [8b+7:8b]
write_data_i  input  NUM_WRITE*DATA_W  packed write data
debug_data_o  output  DATA_W  current contents of DEBUG_REG

Behaviour:
- Reset: reset_i high clears all registers to 0 immediately, asynchronously, without waiting for a clock edge. All read_data_o and debug_data_o read 0 while reset is asserted. Writes are ignored while reset_i is high, and reset wins over any coincident clock edge.
- Write, at the rising edge of clk:
  - For each port w with write_enable_i[w]=1, each byte b with write_strobe_i set is replaced by that byte of write_data_i. Bytes with the strobe clear keep their value.
  - write_enable_i=1 with all strobes 0 is a no-op.
- Register 0 is hardwired to zero. Writes to address 0 are discarded, and reads of address 0 return 0 regardless of any bypass.
- Simultaneous writes to the same register:
  - Merging is per byte.
  - Where both ports strobe the same byte, the higher-indexed port (port 1) wins.
  - Bytes strobed by only one port take that port's data.
- Read, combinational, zero latency: read_data_o[k] = regs[read_addr_i[k]] with the r0 rule applied. Any number of read ports may address the same register.
- debug_data_o: combinational view of regs[DEBUG_REG]. It follows the same bypass rule as the read ports.
- Latency: without bypass, a written value is visible on reads in the cycle after the write edge.
- Out-of-range addresses cannot occur, since NUM_REGS is a power of two.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined: a read (or the debug read) whose address matches an active write port in the same cycle returns the post-write value combinationally.
  - The value is built per byte using the same port-1-wins merge.
  - Unstrobed bytes come from the stored value.
  - Address 0 is still forced to 0.
- Undefined: reads always return stored contents; the same-cycle write becomes visible only after the edge.
- Either way, the register contents after the edge are identical.

Decomposition:
- Package codes:
  - regaddr_t and size_t (existing).
  - New constants REG_ZERO = 0 and REG_V0 = 2.
  - New typedef strobe_t = logic [DATA_W/8-1:0].
- One natural sub-module, regfile_read_port: one read mux, r0 forcing and the optional bypass merge. It is instantiated NUM_READ+1 times via generate, the extra instance serving the debug read.
- The storage array and the write logic stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse reset_i between clock edges. read_data_o for r5 must be 0 before the next rising edge.
- Full-word write: port 0 writes addr 7, strobe 4'b1111, data 0x12345678. After the edge, read port 1 at addr 7 returns 0x12345678. Write the same value to addr 0; read of addr 0 returns 0.
- Byte strobes: r9 = 0xAABBCCDD, then port 0 writes strobe 4'b0101, data 0x11223344. r9 must read 0xAA22CC44.
- Dual-write collision: both ports target r3. Port 0 has strobe 4'b1111, data 0x11111111; port 1 has strobe 4'b0011, data 0x22222222. r3 must read 0x11112222.
- Bypass: r4 = 0, then port 0 writes r4 = 0x55 while read port 0 reads r4 in the same cycle.
  - With REGFILE_WRITE_BYPASS_EN: 0x55 before the edge.
  - Without it: 0 before the edge.
  - 0x55 after the edge in both builds.
- Debug: write 0xCAFEF00D to r2; debug_data_o = 0xCAFEF00D after the edge, and read ports addressing r2 also return it.

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// rtl/regfile_multiport_pkg.sv - shared types and constants for the multiport register file
// Purpose: default geometry, address/strobe typedefs and well-known register indices.
// Ports: none (package).
package regfile_multiport_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;

    typedef logic [RF_ADDR_W-1:0] regaddr_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef logic [RF_DATA_W/8-1:0] strobe_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with r0 forcing and optional write bypass
// Purpose: selects one register, forces address 0 (and reset) to zero and, when
//          REGFILE_WRITE_BYPASS_EN is defined, overlays same-cycle write bytes.
// Ports:
//   i_reset                 asynchronous reset level, forces output to zero
//   i_addr                  register address to read
//   i_regs                  current storage contents
//   i_wr_en/addr/strobe/data write-port view (only with REGFILE_WRITE_BYPASS_EN)
//   o_data                  read result
module regfile_read_port
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
`ifdef REGFILE_WRITE_BYPASS_EN
    ,
    parameter int NUM_WRITE = 2
`endif
) (
    input  logic                          i_reset,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_regs [NUM_REGS],
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic [NUM_WRITE-1:0]          i_wr_en,
    input  logic [NUM_WRITE*ADDR_W-1:0]   i_wr_addr,
    input  logic [NUM_WRITE*DATA_W/8-1:0] i_wr_strobe,
    input  logic [NUM_WRITE*DATA_W-1:0]   i_wr_data,
`endif
    output logic [DATA_W-1:0]             o_data
);

    logic [DATA_W-1:0] w_merged;

    always_comb begin
        w_merged = i_regs[i_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Ascending port order lets port 1 overwrite port 0 on shared bytes,
        // matching the merge applied to storage at the edge.
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == i_addr)) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (i_wr_strobe[w*(DATA_W/8) + b]) begin
                        w_merged[b*8 +: 8] = i_wr_data[w*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
`endif
    end

    assign o_data = (i_reset || (i_addr == ADDR_W'(REG_ZERO))) ? '0 : w_merged;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NUM_REGS x DATA_W register file, NUM_READ reads, NUM_WRITE byte-strobed writes
// Purpose: CPU register file between decode (reads) and writeback (writes), with a
//          fixed debug read of DEBUG_REG. Optional macro: REGFILE_WRITE_BYPASS_EN.
// Ports:
//   clk             rising-edge clock
//   reset_i         asynchronous active-high reset, clears all registers
//   read_addr_i     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   read_data_o     packed read data, port k at [k*DATA_W +: DATA_W]
//   write_enable_i  per-port write enable
//   write_addr_i    packed write addresses
//   write_strobe_i  packed per-port byte strobes
//   write_data_i    packed write data
//   debug_data_o    contents of DEBUG_REG
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int DEBUG_REG = REG_V0
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic [NUM_READ*ADDR_W-1:0]    read_addr_i,
    output logic [NUM_READ*DATA_W-1:0]    read_data_o,
    input  logic [NUM_WRITE-1:0]          write_enable_i,
    input  logic [NUM_WRITE*ADDR_W-1:0]   write_addr_i,
    input  logic [NUM_WRITE*DATA_W/8-1:0] write_strobe_i,
    input  logic [NUM_WRITE*DATA_W-1:0]   write_data_i,
    output logic [DATA_W-1:0]             debug_data_o
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_port_data [NUM_READ+1];

    // Later ports are applied after earlier ones, so port 1 wins shared bytes.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (write_enable_i[w] &&
                    (write_addr_i[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (write_strobe_i[w*BYTES + b]) begin
                            r_regs[write_addr_i[w*ADDR_W +: ADDR_W]][b*8 +: 8]
                                <= write_data_i[w*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Instance NUM_READ is the debug read of DEBUG_REG.
    for (genvar k = 0; k <= NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;

        if (k < NUM_READ) begin : g_port
            assign w_addr = read_addr_i[k*ADDR_W +: ADDR_W];
            assign read_data_o[k*DATA_W +: DATA_W] = w_port_data[k];
        end else begin : g_dbg
            assign w_addr = ADDR_W'(DEBUG_REG);
        end

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
`ifdef REGFILE_WRITE_BYPASS_EN
            ,
            .NUM_WRITE(NUM_WRITE)
`endif
        ) u_rd (
            .i_reset    (reset_i),
            .i_addr     (w_addr),
            .i_regs     (r_regs),
`ifdef REGFILE_WRITE_BYPASS_EN
            .i_wr_en    (write_enable_i),
            .i_wr_addr  (write_addr_i),
            .i_wr_strobe(write_strobe_i),
            .i_wr_data  (write_data_i),
`endif
            .o_data     (w_port_data[k])
        );
    end

    assign debug_data_o = w_port_data[NUM_READ];

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard testbench for regfile_multiport
module tb_regfile_multiport;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int NB  = DW / 8;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_i = 1'b0;
    logic [NRD*AW-1:0]   read_addr_i = '0;
    logic [NRD*DW-1:0]   read_data_o;
    logic [NWR-1:0]      write_enable_i = '0;
    logic [NWR*AW-1:0]   write_addr_i = '0;
    logic [NWR*NB-1:0]   write_strobe_i = '0;
    logic [NWR*DW-1:0]   write_data_i = '0;
    logic [DW-1:0]       debug_data_o;

    regfile_multiport #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .NUM_READ (NRD),
        .NUM_WRITE(NWR),
        .DEBUG_REG(2)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .read_addr_i   (read_addr_i),
        .read_data_o   (read_data_o),
        .write_enable_i(write_enable_i),
        .write_addr_i  (write_addr_i),
        .write_strobe_i(write_strobe_i),
        .write_data_i  (write_data_i),
        .debug_data_o  (debug_data_o)
    );

    always #5 clk = ~clk;

    logic [31:0] m_regs [32];
    logic [95:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    event        chk_ev;

    // Value register a holds once this cycle's writes land: for each byte, the
    // highest-numbered port that strobes it supplies the byte.
    function automatic logic [31:0] post_write(input int a, input logic [1:0] we,
                                               input logic [9:0] wa, input logic [7:0] ws,
                                               input logic [63:0] wd);
        logic [31:0] v;
        v = m_regs[a];
        for (int b = 0; b < NB; b++) begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (we[p] && (int'(wa[p*AW +: AW]) == a) && ws[p*NB + b]) begin
                    v[b*8 +: 8] = wd[p*DW + b*8 +: 8];
                    break;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] read_exp(input int a, input logic [1:0] we,
                                             input logic [9:0] wa, input logic [7:0] ws,
                                             input logic [63:0] wd);
        if (a == 0) return 32'h0;
        if (BYP) return post_write(a, we, wa, ws, wd);
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [1:0] we_in, input logic [9:0] wa, input logic [7:0] ws,
                         input logic [63:0] wd, input logic [9:0] ra, input bit rst);
        logic [95:0] e;
        logic [1:0]  we;
        we = rst ? 2'b00 : we_in;
        @(posedge clk);
        #1;
        write_enable_i = we;
        write_addr_i   = wa;
        write_strobe_i = ws;
        write_data_i   = wd;
        read_addr_i    = ra;
        reset_i        = rst;
        if (rst) e = '0;
        else e = {read_exp(2, we, wa, ws, wd),
                  read_exp(int'(ra[9:5]), we, wa, ws, wd),
                  read_exp(int'(ra[4:0]), we, wa, ws, wd)};
        exp_q.push_back(e);
        ->chk_ev;
        if (rst) begin
            #3;
            reset_i = 1'b0;
            for (int a = 0; a < NR; a++) m_regs[a] = 32'h0;
        end else begin
            for (int a = 1; a < NR; a++) m_regs[a] = post_write(a, we, wa, ws, wd);
        end
    endtask

    // Monitor: samples mid-cycle whenever a stimulus cycle has been presented.
    initial begin
        logic [95:0] e;
        forever begin
            @(chk_ev);
            #2;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue: got empty scoreboard expected an entry");
            end else begin
                e = exp_q.pop_front();
                check("rd0", read_data_o[31:0],  e[31:0]);
                check("rd1", read_data_o[63:32], e[63:32]);
                check("dbg", debug_data_o,       e[95:64]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  we;
        logic [9:0]  wa;
        logic [7:0]  ws;
        logic [63:0] wd;
        logic [9:0]  ra;
        for (int a = 0; a < NR; a++) m_regs[a] = 32'h0;
        #2 reset_i = 1'b1;

        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd2, 5'd5}, 1'b1);
        // reset mid-cycle after r5 holds a value
        cycle(2'b01, {5'd0, 5'd5}, 8'h0F, {32'h0, 32'hDEADBEEF}, {5'd5, 5'd5}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd5, 5'd5}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd5, 5'd5}, 1'b1);
        // full-word write and r0 discard
        cycle(2'b01, {5'd0, 5'd7}, 8'h0F, {32'h0, 32'h12345678}, {5'd7, 5'd0}, 1'b0);
        cycle(2'b01, {5'd0, 5'd0}, 8'h0F, {32'h0, 32'h12345678}, {5'd7, 5'd0}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd0, 5'd0}, 1'b0);
        // byte strobes
        cycle(2'b01, {5'd0, 5'd9}, 8'h0F, {32'h0, 32'hAABBCCDD}, {5'd9, 5'd9}, 1'b0);
        cycle(2'b01, {5'd0, 5'd9}, 8'h05, {32'h0, 32'h11223344}, {5'd9, 5'd9}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd9, 5'd9}, 1'b0);
        // dual-write collision
        cycle(2'b11, {5'd3, 5'd3}, {4'b0011, 4'b1111}, {32'h22222222, 32'h11111111},
              {5'd3, 5'd3}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd3, 5'd3}, 1'b0);
        // same-cycle read of a register being written
        cycle(2'b01, {5'd0, 5'd4}, 8'h0F, {32'h0, 32'h0}, {5'd4, 5'd4}, 1'b0);
        cycle(2'b01, {5'd0, 5'd4}, 8'h0F, {32'h0, 32'h55}, {5'd0, 5'd4}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd4, 5'd4}, 1'b0);
        // debug register
        cycle(2'b01, {5'd0, 5'd2}, 8'h0F, {32'h0, 32'hCAFEF00D}, {5'd2, 5'd2}, 1'b0);
        cycle(2'b00, 10'd0, 8'h00, 64'h0, {5'd2, 5'd2}, 1'b0);

        for (int i = 0; i < 500; i++) begin
            we = 2'($urandom_range(0, 3));
            for (int p = 0; p < NWR; p++) begin
                wa[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                             : 5'($urandom_range(0, 31));
            end
            ws = 8'($urandom);
            wd = {$urandom, $urandom};
            for (int k = 0; k < NRD; k++) begin
                case ($urandom_range(0, 3))
                    0:       ra[k*AW +: AW] = wa[4:0];
                    1:       ra[k*AW +: AW] = wa[9:5];
                    default: ra[k*AW +: AW] = 5'($urandom_range(0, 31));
                endcase
            end
            cycle(we, wa, ws, wd, ra, ($urandom_range(0, 63) == 0));
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
